// File: rtl/param_stack.sv
// Parametrised LIFO stack: registered pop data, combinational peek of the top
// entry, status flags from the stack pointer and one-cycle overflow/underflow pulses.
module param_stack #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp_reg;
  logic [CW-1:0]    sp_dec;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic [WIDTH-1:0] top_word;
  logic [WIDTH-1:0] data_out_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  assign sp_dec   = sp_reg - CW'(1);
  assign rd_idx   = sp_dec[AW-1:0];
  assign top_word = mem[rd_idx];

  assign empty       = (sp_reg == '0);
  assign full        = (sp_reg == CW'(DEPTH));
  assign almost_full = (sp_reg >= CW'(ALMOST_FULL));
  assign count       = sp_reg;
  assign top         = empty ? '0 : top_word;
  assign data_out    = data_out_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // Replace-top writes over the current top; every other accepted push
  // (including push+pop on empty, where sp is 0) writes at sp.
  assign wr_en  = push && !rst && (pop || !full);
  assign wr_idx = (pop && !empty) ? rd_idx : sp_reg[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg        <= '0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      case ({push, pop})
        2'b10: begin
          if (full) begin
            overflow_reg <= 1'b1;
          end else begin
            sp_reg <= sp_reg + CW'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            underflow_reg <= 1'b1;
          end else begin
            data_out_reg <= top_word;
            sp_reg       <= sp_dec;
          end
        end
        2'b11: begin
          if (empty) begin
            sp_reg        <= CW'(1);
            underflow_reg <= 1'b1;
          end else begin
            data_out_reg <= top_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at default parameters: reset, fill/overflow,
// drain/underflow, replace-top, empty push+pop and reset mid-stream.
module tb_param_stack;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] top;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  param_stack #(.WIDTH(8), .DEPTH(16), .ALMOST_FULL(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .data_out    (data_out),
    .top         (top),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; push = 1'b1; pop = 1'b0; data_in = 8'hFF;
    tick(); tick();
    $display("reset: count=%0d empty=%0b top=0x%0h", count, empty, top);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_top", top, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Fill with 0x01..0x10
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; data_in = 8'(i);
      tick();
      $display("push 0x%0h: count=%0d top=0x%0h af=%0b full=%0b", data_in, count, top, almost_full, full);
      chk("fill_count", count, i);
      chk("fill_top", top, i);
      chk("fill_af", almost_full, (i >= 14) ? 1 : 0);
      chk("fill_full", full, (i == 16) ? 1 : 0);
    end

    data_in = 8'hAA;
    tick();
    $display("push 0xaa at full: ovf=%0b count=%0d top=0x%0h", overflow, count, top);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_top", top, 8'h10);
    push = 1'b0;
    tick();
    $display("idle: ovf=%0b", overflow);
    chk("ovf_clear", overflow, 0);

    // Drain
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      tick();
      $display("pop: data_out=0x%0h count=%0d", data_out, count);
      chk("drain_data", data_out, 16 - i);
      chk("drain_count", count, 15 - i);
    end
    chk("drain_empty", empty, 1);
    tick();
    $display("pop at empty: unf=%0b data_out=0x%0h count=%0d", underflow, data_out, count);
    chk("unf_pulse", underflow, 1);
    chk("unf_data_hold", data_out, 1);
    chk("unf_count", count, 0);
    pop = 1'b0;
    tick();
    $display("idle: unf=%0b", underflow);
    chk("unf_clear", underflow, 0);

    // Replace-top with two entries
    push = 1'b1; data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    pop = 1'b1; data_in = 8'h33; tick();
    $display("push+pop 0x33: data_out=0x%0h top=0x%0h count=%0d", data_out, top, count);
    chk("rt_data", data_out, 8'h22);
    chk("rt_top", top, 8'h33);
    chk("rt_count", count, 2);

    // Fill to full with 0x40..0x4D, then replace-top at full
    pop = 1'b0;
    for (int k = 0; k < 14; k++) begin
      data_in = 8'(8'h40 + k);
      tick();
    end
    chk("rtf_full", full, 1);
    chk("rtf_pre_top", top, 8'h4D);
    pop = 1'b1; data_in = 8'h77; tick();
    $display("push+pop 0x77 at full: data_out=0x%0h top=0x%0h count=%0d ovf=%0b", data_out, top, count, overflow);
    chk("rtf_data", data_out, 8'h4D);
    chk("rtf_top", top, 8'h77);
    chk("rtf_count", count, 16);
    chk("rtf_ovf", overflow, 0);
    chk("rtf_unf", underflow, 0);

    // Drain to empty; last word popped is the bottom entry 0x11
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    $display("drained: data_out=0x%0h empty=%0b", data_out, empty);
    chk("drain2_data", data_out, 8'h11);
    chk("drain2_empty", empty, 1);

    // Push+pop on empty
    push = 1'b1; data_in = 8'h5A; tick();
    $display("push+pop 0x5a at empty: count=%0d top=0x%0h unf=%0b data_out=0x%0h", count, top, underflow, data_out);
    chk("ep_count", count, 1);
    chk("ep_top", top, 8'h5A);
    chk("ep_unf", underflow, 1);
    chk("ep_data_hold", data_out, 8'h11);
    push = 1'b0; pop = 1'b0; tick();
    chk("ep_unf_clear", underflow, 0);

    // Reset mid-stream
    push = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_in = 8'(8'hC0 + k);
      tick();
    end
    chk("mid_count", count, 6);
    push = 1'b0; pop = 1'b1; rst = 1'b1; tick();
    $display("rst+pop: count=%0d empty=%0b data_out=0x%0h unf=%0b", count, empty, data_out, underflow);
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_data", data_out, 0);
    chk("mr_unf", underflow, 0);
    chk("mr_top", top, 0);
    rst = 1'b0; pop = 1'b0; push = 1'b1; data_in = 8'h3C; tick();
    $display("push 0x3c: top=0x%0h count=%0d", top, count);
    chk("mr_push_top", top, 8'h3C);
    chk("mr_push_count", count, 1);
    push = 1'b0; tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack with registered pop data, full/empty/almost-full status, per-cycle overflow/underflow error pulses and same-cycle push+pop (replace-top). It is the next-generation stack block for datapaths that need configurable word width and depth with protected boundaries. It sits between a producer issuing `push` and a consumer issuing `pop`. The stack is single-clock with no cross-domain logic.

## Interface
- `WIDTH`, 8: data word width in bits (>= 1).
- `DEPTH`, 16: number of storage entries (>= 2).
- `ALMOST_FULL`, DEPTH-2: `almost_full` asserts when `count >= ALMOST_FULL` (1..DEPTH).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `push`  in  1  write `data_in` onto the top of the stack this cycle.
- `pop`  in  1  remove the top entry this cycle and register it to `data_out`.
- `data_in`  in  WIDTH  word to push.
- `data_out`  out  WIDTH  last popped word (registered).
- `top`  out  WIDTH  current top-of-stack (peek); 0 when empty.
- `count`  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `almost_full`  out  1  `count >= ALMOST_FULL`.
- `overflow`  out  1  one-cycle pulse: a push was rejected.
- `underflow`  out  1  one-cycle pulse: a pop was rejected.

## Operation
- Storage: DEPTH x WIDTH register array plus stack pointer `sp` (= `count`). Array contents are not reset. `top` reads `mem[sp-1]` and is forced to 0 when `sp == 0`.
- Priority: `rst` overrides everything. Otherwise the cycle is decoded from {push, pop, empty, full}:
  - Push only, not full: `mem[sp] <= data_in`, `sp <= sp+1`.
  - Push only, full: rejected. `overflow <= 1`; no state change.
  - Pop only, not empty: `data_out <= mem[sp-1]`, `sp <= sp-1`.
  - Pop only, empty: rejected. `underflow <= 1`; `data_out` holds its value.
  - Push+pop, not empty (including full): replace-top. `data_out <= mem[sp-1]`, `mem[sp-1] <= data_in`, `sp` unchanged. No overflow is reported.
  - Push+pop, empty: the push executes as push-only (`sp <= 1`) and `underflow <= 1`. `data_out` holds its value.
  - Neither: hold. `overflow` and `underflow` return to 0.
- `overflow` and `underflow` are registered and deasserted in every cycle without a rejected request. They are not sticky.
- Status flags `empty`, `full` and `almost_full` are combinational from registered `sp`, so they are glitch-free relative to `clk`.

## Timing
- Reset values: `sp`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0 (1 if ALMOST_FULL would be 0, which is disallowed), `data_out`=0, `top`=0, `overflow`=0, `underflow`=0.
- Reset mid-operation clears `sp` on the same edge it is sampled high. A push or pop issued with `rst` high is discarded, and no error pulse is produced.
- Latency:
  - Pop data appears on `data_out` one edge after `pop` is sampled.
  - `top`, `count` and the flags reflect a push or pop one edge after the request.
  - Error pulses are high for exactly the cycle following the rejected request.
- Back-to-back push or pop every cycle is supported at full rate. There are no stall cycles.
- Pointer arithmetic is `$clog2(DEPTH+1)` wide and never wraps: `sp` saturates by rejection at 0 and at DEPTH.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `push`=1 and `data_in`=0xFF. Required: `count`=0, `empty`=1, `full`=0, `data_out`=0, `top`=0, no error pulses.
- Fill and overflow (defaults): push 0x01..0x10 on 16 consecutive cycles. Required: `almost_full` rises when `count`=14, `full`=1 when `count`=16, `top`=0x10. A 17th push of 0xAA gives `overflow`=1 for one cycle, with `count`=16 and `top`=0x10 unchanged.
- Drain and underflow: pop 16 times from full. Required: `data_out` sequence 0x10, 0x0F, …, 0x01, then `empty`=1. A further pop gives `underflow`=1 for one cycle, with `data_out` holding 0x01 and `count`=0.
- Replace-top: with the stack holding 0x11 and 0x22 (top 0x22), assert push+pop with 0x33. Required: `data_out`=0x22, `top`=0x33, `count`=2. Repeat at full with 0x77: `data_out`=old top, `top`=0x77, `count`=16, `overflow`=0.
- Empty push+pop: from empty, push+pop with 0x5A. Required: `count`=1, `top`=0x5A, `underflow`=1 for one cycle, `data_out` unchanged.
- Reset mid-stream: push 5 words, then assert `rst` together with `pop`. Required: next edge gives `count`=0, `empty`=1, `data_out`=0, `underflow`=0. A subsequent push of 0x3C gives `top`=0x3C and `count`=1.
